// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter over four requesters driving a registered 4:1 data mux.
// Define MUX_ARB_TIMEOUT_EN to force rotation after MAX_HOLD grant cycles.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       out,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, nstate;
  logic [1:0] ptr, nptr;
  logic [1:0] sel_q, nsel;
  logic [3:0] gnt_q, ngnt;
  logic       out_q, nout;
  logic       pre_q, npreempt;
  logic       handover;
  logic       expire;
  logic [2:0] win;

  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD must be at least 1");
  end

  // Returns {found, index} of the first set bit scanning upward from start (mod 4).
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] i;
    pick = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      i = start + 2'(k);
      if (!pick[2] && r[i]) pick = {1'b1, i};
    end
  endfunction

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt, ncnt;

  // Forced rotation only when someone else is waiting; otherwise the counter saturates.
  assign expire = (state == GRANT) && (cnt >= CW'(MAX_HOLD)) && ((req & ~gnt_q) != '0);

  always_comb begin
    ncnt = '0;
    if (nstate == GRANT) begin
      if (handover)                 ncnt = CW'(1);
      else if (cnt < CW'(MAX_HOLD)) ncnt = cnt + CW'(1);
      else                          ncnt = cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= ncnt;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel_q <= '0;
      gnt_q <= '0;
      out_q <= 1'b0;
      pre_q <= 1'b0;
    end else begin
      state <= nstate;
      ptr   <= nptr;
      sel_q <= nsel;
      gnt_q <= ngnt;
      out_q <= nout;
      pre_q <= npreempt;
    end
  end

  always_comb begin
    nstate   = state;
    nptr     = ptr;
    nsel     = sel_q;
    npreempt = 1'b0;
    handover = 1'b0;
    win      = '0;
    case (state)
      IDLE: begin
        handover = 1'b1;
        win      = pick(req, ptr);
        if (win[2]) begin
          nstate = GRANT;
          nsel   = win[1:0];
        end
      end
      GRANT: begin
        // Handover searches from the slot after the releasing source, so it is served last.
        if (!req[sel_q] || expire) begin
          handover = 1'b1;
          npreempt = expire;
          nptr     = sel_q + 2'd1;
          win      = pick(req, sel_q + 2'd1);
          if (win[2]) begin
            nstate = GRANT;
            nsel   = win[1:0];
          end else begin
            nstate = IDLE;
          end
        end
      end
      default: nstate = IDLE;
    endcase
    ngnt = (nstate == GRANT) ? (4'b0001 << nsel) : '0;
    nout = (nstate == GRANT) ? d[nsel] : 1'b0;
  end

  always_comb begin
    gnt     = gnt_q;
    sel     = sel_q;
    out     = out_q;
    preempt = pre_q;
    busy    = (state == GRANT);
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed scenarios plus randomized traffic.
// Expected values come from a cycle model; define MUX_ARB_TIMEOUT_EN to test rotation.
module tb_mux_rr_arbiter;

  localparam int MAXH = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       out;
    logic       busy;
    logic       preempt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out;
  logic       busy;
  logic       preempt;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  int m_busy, m_sel, m_ptr, m_cnt;

  mux_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .d       (d),
    .gnt     (gnt),
    .sel     (sel),
    .out     (out),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Next-cycle reference for one rising edge with the given inputs.
  task automatic model(input logic r, input logic [3:0] rq, input logic [3:0] dd, output exp_t e);
    int  start, found;
    bit  held, tmo;
    e.preempt = 1'b0;
    if (r) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      held = (m_busy != 0) && rq[m_sel];
      tmo  = TMO && held && (m_cnt >= MAXH) && ((rq & ~(4'b0001 << m_sel)) != 4'b0000);
      if (held && !tmo) begin
        if (m_cnt < MAXH) m_cnt++;
      end else begin
        if (m_busy != 0) m_ptr = (m_sel + 1) % 4;
        start = m_ptr;
        found = -1;
        for (int k = 0; k < 4; k++)
          if (found < 0 && rq[(start + k) % 4]) found = (start + k) % 4;
        if (found >= 0) begin
          m_busy = 1; m_sel = found; m_cnt = 1; e.preempt = tmo;
        end else begin
          m_busy = 0; m_cnt = 0;
        end
      end
    end
    e.busy = (m_busy != 0);
    e.sel  = 2'(m_sel);
    e.gnt  = (m_busy != 0) ? (4'b0001 << m_sel) : 4'b0000;
    e.out  = (m_busy != 0) ? dd[m_sel] : 1'b0;
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dd);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; d = dd;
    model(r, rq, dd, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("gnt", 32'(gnt), 32'(e.gnt));
      check("sel", 32'(sel), 32'(e.sel));
      check("out", 32'(out), 32'(e.out));
      check("busy", 32'(busy), 32'(e.busy));
      check("preempt", 32'(preempt), 32'(e.preempt));
      check("onehot", 32'($onehot0(gnt)), 32'd1);
    end
  endtask

  initial begin
    logic [3:0] rq, dd;
    rst = 1'b0; req = '0; d = '0;

    // Reset with all requests asserted, then release.
    step(1'b1, 4'b1111, 4'b1111);
    step(1'b1, 4'b1111, 4'b1111);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    step(1'b0, 4'b1111, 4'b1111);
    check("rel_gnt", 32'(gnt), 32'h1);

    // Each winner holds two cycles then drops for one; expect 1,2,3,0 with no gap.
    for (int s = 0; s < 4; s++) begin
      step(1'b0, 4'b1111, 4'b0000);
      step(1'b0, 4'b1111 & ~(4'b0001 << s), 4'b0000);
      check("rr_gnt", 32'(gnt), 32'(4'b0001 << ((s + 1) % 4)));
      check("rr_busy", 32'(busy), 32'h1);
    end

    // Data path follows d[2] only.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, 4'b1111);
    check("dp_on", 32'(out), 32'h1);
    step(1'b0, 4'b0100, 4'b1011);
    check("dp_off", 32'(out), 32'h0);
    step(1'b0, 4'b0100, 4'b0000);
    check("dp_others", 32'(out), 32'h0);
    step(1'b0, 4'b0100, 4'b0101);
    check("dp_back", 32'(out), 32'h1);

    // Single requester 3, release, then pointer should sit at 0.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b1000, 4'b1000);
    check("single_gnt", 32'(gnt), 32'h8);
    check("single_sel", 32'(sel), 32'h3);
    step(1'b0, 4'b0000, 4'b1000);
    check("single_idle", 32'(gnt), 32'h0);
    check("single_selhold", 32'(sel), 32'h3);
    step(1'b0, 4'b1111, 4'b0000);
    check("single_ptr", 32'(gnt), 32'h1);

    // Reset in the middle of a grant.
    step(1'b1, 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, 4'b0000);
    check("mid_gnt", 32'(gnt), 32'h4);
    step(1'b1, 4'b0100, 4'b1111);
    check("mid_rst", 32'(gnt), 32'h0);
    step(1'b0, 4'b0101, 4'b0000);
    check("mid_after", 32'(gnt), 32'h1);

    // Two steady requesters: rotation after MAXH cycles only when the timeout is built in.
    step(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < MAXH; i++) step(1'b0, 4'b0011, 4'b0010);
    check("tmo_hold", 32'(gnt), 32'h1);
    step(1'b0, 4'b0011, 4'b0010);
    check("tmo_gnt", 32'(gnt), TMO ? 32'h2 : 32'h1);
    check("tmo_pulse", 32'(preempt), 32'(TMO));
    for (int i = 0; i < 2 * MAXH; i++) step(1'b0, 4'b0011, 4'b0011);

    // Lone requester never rotates.
    for (int i = 0; i < 3 * MAXH; i++) step(1'b0, 4'b0001, 4'b0001);
    check("sat_gnt", 32'(gnt), 32'h1);

    // Random traffic with sticky requests and occasional reset.
    rq = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 40) rq = 4'($urandom);
      dd = 4'($urandom);
      step(($urandom_range(0, 99) < 3), rq, dd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
